bcd_ex3_seq_ctrl: RTL and testbench

//  Sequencer for multi-digit BCD-to-excess-3 conversion over a single shared 4-bit digit converter.
//  - Accepts an NDIG-digit packed BCD word on a valid/ready handshake.
//  - Time-multiplexes the bcd_ex3_digit converter across the digits, one digit per clock, LSD first.
//  - Presents the excess-3 word on a valid/ready output port.
//  - Sits between a BCD producer (counter/display path) and an excess-3 consumer.

---
 rtl/bcd_ex3_pkg.sv | 26 ++
 rtl/bcd_ex3_seq_ctrl_if.sv | 58 +++++
 rtl/bcd_ex3_digit.sv | 11 +
 rtl/bcd_ex3_seq_ctrl.sv | 114 +++++++++++
 tb/tb_bcd_ex3_seq_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/bcd_ex3_pkg.sv
// Shared types and constants for the BCD to excess-3 sequencer.
// Optional BCD_CHECK_EN adds an invalid-digit flag.
package bcd_ex3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam logic [3:0] EX3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  function automatic logic [3:0] ex3_of(
    input logic [3:0] d
  );
    return d + EX3_OFFSET;
  endfunction

  function automatic logic bcd_bad(
    input logic [3:0] d
  );
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_ex3_seq_ctrl_if.sv
// Producer/consumer handshake bundle for bcd_ex3_seq_ctrl.
// err exists only when BCD_CHECK_EN is defined.
interface bcd_ex3_seq_ctrl_if #(
  parameter int NDIG = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [4*NDIG-1:0]   in_bcd;
  logic                out_valid;
  logic                out_ready;
  logic [4*NDIG-1:0]   out_ex3;
  logic                busy;
`ifdef BCD_CHECK_EN
  logic                err;

  modport slave (
    input  in_valid,
    input  in_bcd,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_ex3,
    output busy,
    output err
  );

  modport master (
    output in_valid,
    output in_bcd,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_ex3,
    input  busy,
    input  err
  );
`else
  modport slave (
    input  in_valid,
    input  in_bcd,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_ex3,
    output busy
  );

  modport master (
    output in_valid,
    output in_bcd,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_ex3,
    input  busy
  );
`endif
endinterface

// File: rtl/bcd_ex3_digit.sv
// Single-digit BCD to excess-3 converter (add 3, carry dropped).
import bcd_ex3_pkg::*;

module bcd_ex3_digit (
  input  logic [3:0] bcd,
  output logic [3:0] ex3
);

  assign ex3 = ex3_of(bcd);

endmodule

// File: rtl/bcd_ex3_seq_ctrl.sv
// Multi-digit BCD to excess-3 sequencer, one digit per clock, LSD first.
// Define BCD_CHECK_EN to flag operand digits above 9 on err.
import bcd_ex3_pkg::*;

module bcd_ex3_seq_ctrl #(
  parameter int NDIG = 4
) (
  input  logic clk,
  input  logic rst_n,
  bcd_ex3_seq_ctrl_if.slave bus
);

  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    operand;
  logic [W-1:0]    result;
  logic            out_valid_q;
  logic            in_ready_q;
  logic            busy_q;
  logic [3:0]      cur;
  logic [3:0]      ex3;

  always_comb begin
    cur = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx == IW'(k)) cur = operand[4*k +: 4];
    end
  end

  bcd_ex3_digit u_digit (
    .bcd (cur),
    .ex3 (ex3)
  );

`ifdef BCD_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) err_q <= 1'b0;
        CONV: if (bcd_bad(cur)) err_q <= 1'b1;
        DONE: if (bus.out_ready) err_q <= 1'b0;
        default: err_q <= 1'b0;
      endcase
    end
  end

  assign bus.err = err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      operand     <= '0;
      result      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            operand    <= bus.in_bcd;
            idx        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          for (int k = 0; k < NDIG; k++) begin
            if (idx == IW'(k)) result[4*k +: 4] <= ex3;
          end
          if (idx == LAST) begin
            idx         <= '0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          // result is frozen here; only the consumer can release it
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ex3   = result;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
// Directed bench for bcd_ex3_seq_ctrl with NDIG=4.
module tb_bcd_ex3_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;

  bcd_ex3_seq_ctrl_if #(.NDIG(4)) bus ();

  bcd_ex3_seq_ctrl #(.NDIG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] w);
    bus.in_valid = 1'b1;
    bus.in_bcd   = w;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_conv(input string tag, input logic [15:0] exp);
    for (int i = 1; i < 4; i++) begin
      step();
      chk({tag, "_cv"}, {31'd0, bus.out_valid}, 32'd0);
    end
    step();
    chk({tag, "_ov"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_ex3"}, {16'd0, bus.out_ex3}, {16'd0, exp});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_ex3", {16'd0, bus.out_ex3}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef BCD_CHECK_EN
    chk("rst_err", {31'd0, bus.err}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: basic latency, in_bcd change after accept is ignored
    bus.out_ready = 1'b1;
    accept(16'h1234);
    bus.in_bcd = 16'hFFFF;
    chk("t1_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t1_cv", {31'd0, bus.out_valid}, 32'd0);
      chk("t1_rdy", {31'd0, bus.in_ready}, 32'd0);
    end
    step();
    chk("t1_ov", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_ex3", {16'd0, bus.out_ex3}, 32'h4567);
    chk("t1_rdy_dn", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("t1_idle_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("t1_idle_rdy", {31'd0, bus.in_ready}, 32'd1);

    // 2: back-to-back words
    accept(16'h9999);
    finish_conv("t2a", 16'hCCCC);
    bus.in_valid = 1'b1;
    bus.in_bcd   = 16'h0000;
    step();
    chk("t2_hs_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("t2_hs_rdy", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("t2_acc_busy", {31'd0, bus.busy}, 32'd1);
    finish_conv("t2b", 16'h3333);
    step();

    // 3: backpressure in DONE with a pending producer word
    bus.out_ready = 1'b0;
    accept(16'h0246);
    finish_conv("t3a", 16'h3579);
    bus.in_valid = 1'b1;
    bus.in_bcd   = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_ov", {31'd0, bus.out_valid}, 32'd1);
      chk("t3_hold_ex3", {16'd0, bus.out_ex3}, 32'h3579);
      chk("t3_hold_rdy", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("t3_hs_rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("t3_hs_ex3", {16'd0, bus.out_ex3}, 32'h3579);
    step();
    bus.in_valid = 1'b0;
    finish_conv("t3b", 16'h8888);
    step();

    // 4: async reset on the second CONV cycle
    accept(16'h8765);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("t4_ex3", {16'd0, bus.out_ex3}, 32'd0);
    chk("t4_rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("t4_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    accept(16'h0001);
    finish_conv("t4b", 16'h3334);
    step();

    // 5: invalid digit wraps, optional error flag
    accept(16'h00A0);
    finish_conv("t5a", 16'h33D3);
`ifdef BCD_CHECK_EN
    chk("t5_err1", {31'd0, bus.err}, 32'd1);
`endif
    step();
`ifdef BCD_CHECK_EN
    chk("t5_err_idle", {31'd0, bus.err}, 32'd0);
`endif
    accept(16'h0123);
    finish_conv("t5b", 16'h3456);
`ifdef BCD_CHECK_EN
    chk("t5_err0", {31'd0, bus.err}, 32'd0);
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
